decode_issue: RTL and testbench
===============================

# decode_issue

Decode/issue stage feeding the execute-stage ALU. It accepts 32-bit DLX instructions over a valid/ready handshake and reads source operands from the register file, with writeback forwarding. Each accepted instruction is translated into the ALU control bus (`alu_opcode`, `alu_function`, `alu_data_in_a`, `alu_data_in_b`) plus destination info, and held in a single output pipeline register with its own valid/ready handshake toward execute.

## Interface
- `DATA_WIDTH`, 32, operand width (≥16).
- `OPCODE_WIDTH`, 3, width of `alu_opcode`/`alu_function`.
- `REG_ADDR_WIDTH`, 5, register index width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: discard the held instruction; block acceptance this cycle.
- `instr_valid` in 1: instruction offered.
- `instr_ready` out 1: instruction accepted when both `instr_valid` and `instr_ready` are high.
- `instr_data` in 32: DLX instruction word.
- `rf_rd_addr_a`, `rf_rd_addr_b` out REG_ADDR_WIDTH: combinational register-file read addresses.
- `rf_rd_data_a`, `rf_rd_data_b` in DATA_WIDTH: combinational read data.
- `wb_en` in 1, `wb_addr` in REG_ADDR_WIDTH, `wb_data` in DATA_WIDTH: writeback port, forwarded.
- `alu_valid` out 1, `alu_ready` in 1: issue handshake.
- `alu_data_in_a`, `alu_data_in_b` out DATA_WIDTH: operands.
- `alu_opcode`, `alu_function` out OPCODE_WIDTH: ALU control.
- `alu_rd_en` out 1, `alu_rd_addr` out REG_ADDR_WIDTH: destination register.
- `illegal_instr` out 1: one-cycle pulse when an undecodable instruction is consumed.

## Operation
- Fields: op=`instr[31:26]`, rs1=`[25:21]`; R-type rs2=`[20:16]`, rd=`[15:11]`, func=`[5:0]`; I-type rd=`[20:16]`, imm=`[15:0]`.
- ALU codes: opcode TYPE_R=0, ADDI=1, SUBI=2, ANDI=3, ORI=4. Function ADD=0, SUB=1, AND=2, OR=3, MULT=4, DIV=5, CMP=6, NOT=7.
- op 6'h00 → TYPE_R. func mapping: 6'h20 ADD, 6'h22 SUB, 6'h24 AND, 6'h25 OR, 6'h0E MULT, 6'h0F DIV, 6'h28 CMP, 6'h2F NOT. `alu_data_in_b` = rs2 value.
- op 6'h08 ADDI and 6'h0A SUBI: imm is sign-extended. 6'h0C ANDI and 6'h0D ORI: imm is zero-extended. `alu_data_in_b` = extended imm. `alu_function` = 0.
- Any other op or func is illegal. On accept it is not issued: `alu_valid` stays 0, and `illegal_instr` goes to 1 for the next cycle only.
- Operand source: register 0 reads as 0. If `wb_en` and `wb_addr == rs` (rs ≠ 0), use `wb_data`. Otherwise use the register-file data.
- `alu_rd_en` = 1 for every legal instruction, except when rd = 0, where `alu_rd_en` = 0.
- Stall hold: while `alu_valid` and not `alu_ready`, all outputs hold, except an operand is replaced by `wb_data` when `wb_en`, `wb_addr` ≠ 0, and `wb_addr` equals that operand's held source register. Immediates are never replaced. The source registers are stored alongside the payload.
- `rf_rd_addr_a` = rs1 and `rf_rd_addr_b` = rs2 field of `instr_data`, always, regardless of valid.

## Timing
- Reset: `alu_valid`, `illegal_instr`, `alu_rd_en` = 0; all data, address, opcode and function outputs = 0. `instr_ready` = 1 after reset (when `flush` = 0).
- `instr_ready` = !`flush` & (!`alu_valid` | `alu_ready`). This is full throughput: one instruction per cycle when `alu_ready` stays high.
- Latency: accept in cycle N → `alu_valid` = 1 in cycle N+1 with the decoded payload.
- Simultaneous retire and accept (`alu_valid` & `alu_ready` & `instr_valid`): the new payload replaces the old with no bubble.
- Retire with no new instruction: `alu_valid` → 0 next cycle.
- `flush`: `alu_valid` → 0 next cycle. No accept occurs and `illegal_instr` does not pulse. Flush wins over `alu_ready`.
- `rst` asserted mid-stall: outputs go to reset values immediately (asynchronous). The held instruction is lost.

## Test plan
- Reset, then ADDI r3,r1,-1 (0x2023FFFF) with r1=5 from the register file → next cycle `alu_valid`=1, opcode=1, a=5, b=0xFFFFFFFF, `alu_rd_addr`=3, `alu_rd_en`=1.
- ORI r2,r0,0x8000 → a=0, b=0x00008000 (zero-extended), opcode=4.
- R-type SUB r4,r1,r2 with `wb_en`=1, `wb_addr`=2, `wb_data`=7, RF r2=9 → b=7, opcode=0, function=1.
- Stall: hold `alu_ready`=0 for 3 cycles after ADD r5,r6,r7 is issued; pulse wb r7=0x55 in the second cycle → `alu_data_in_b` becomes 0x55, other outputs stable, `instr_ready`=0 throughout.
- Illegal op 6'h3F → no `alu_valid`; `illegal_instr`=1 for exactly one cycle. Back-to-back legal instructions with `alu_ready`=1 → one issue per cycle, no bubbles.
- `flush` asserted while stalled with `instr_valid`=1 → `alu_valid`=0 next cycle, instruction not accepted. `rst` mid-stall → all outputs 0 asynchronously.

Source files
------------

// File: rtl/decode_issue.sv
// Decode/issue stage: turns DLX instruction words into ALU control plus
// operands, reads the register file with writeback forwarding, and holds the
// result in one output register toward the execute stage.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. instr_ready depends only on flush, alu_valid and alu_ready, never
// on instr_valid. Once alu_valid is high the payload holds until alu_ready is
// seen high or a flush arrives. The only change allowed while held is
// forwarding of a writeback into a register-sourced operand.
module decode_issue #(
  parameter int DATA_WIDTH     = 32,
  parameter int OPCODE_WIDTH   = 3,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [31:0]               instr_data,
  output logic [REG_ADDR_WIDTH-1:0] rf_rd_addr_a,
  output logic [REG_ADDR_WIDTH-1:0] rf_rd_addr_b,
  input  logic [DATA_WIDTH-1:0]     rf_rd_data_a,
  input  logic [DATA_WIDTH-1:0]     rf_rd_data_b,
  input  logic                      wb_en,
  input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  output logic                      alu_valid,
  input  logic                      alu_ready,
  output logic [DATA_WIDTH-1:0]     alu_data_in_a,
  output logic [DATA_WIDTH-1:0]     alu_data_in_b,
  output logic [OPCODE_WIDTH-1:0]   alu_opcode,
  output logic [OPCODE_WIDTH-1:0]   alu_function,
  output logic                      alu_rd_en,
  output logic [REG_ADDR_WIDTH-1:0] alu_rd_addr,
  output logic                      illegal_instr
);

  localparam logic [OPCODE_WIDTH-1:0] OPC_TYPE_R = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OPC_ADDI   = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OPC_SUBI   = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OPC_ANDI   = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OPC_ORI    = OPCODE_WIDTH'(4);

  // Instruction fields
  logic [5:0]                op;
  logic [5:0]                func;
  logic [REG_ADDR_WIDTH-1:0] rs1;
  logic [REG_ADDR_WIDTH-1:0] rs2;
  logic [REG_ADDR_WIDTH-1:0] rd_r;
  logic [REG_ADDR_WIDTH-1:0] rd_i;
  logic signed [15:0]        imm_s;
  logic [DATA_WIDTH-1:0]     imm_sext;
  logic [DATA_WIDTH-1:0]     imm_zext;
  logic                      unused_shamt;

  assign op           = instr_data[31:26];
  assign func         = instr_data[5:0];
  assign rs1          = REG_ADDR_WIDTH'(instr_data[25:21]);
  assign rs2          = REG_ADDR_WIDTH'(instr_data[20:16]);
  assign rd_r         = REG_ADDR_WIDTH'(instr_data[15:11]);
  assign rd_i         = REG_ADDR_WIDTH'(instr_data[20:16]);
  assign imm_s        = instr_data[15:0];
  assign imm_sext     = DATA_WIDTH'(imm_s);
  assign imm_zext     = DATA_WIDTH'(instr_data[15:0]);
  assign unused_shamt = ^instr_data[10:6];

  assign rf_rd_addr_a = rs1;
  assign rf_rd_addr_b = rs2;

  // Decoded payload
  logic                      dec_legal;
  logic [OPCODE_WIDTH-1:0]   dec_opcode;
  logic [OPCODE_WIDTH-1:0]   dec_function;
  logic                      dec_b_reg;
  logic [REG_ADDR_WIDTH-1:0] dec_rd;
  logic [DATA_WIDTH-1:0]     dec_a;
  logic [DATA_WIDTH-1:0]     dec_b;
  logic [DATA_WIDTH-1:0]     opnd_a;
  logic [DATA_WIDTH-1:0]     opnd_b;

  // Held source registers, used to forward writebacks into a stalled payload
  logic [REG_ADDR_WIDTH-1:0] src_a;
  logic [REG_ADDR_WIDTH-1:0] src_b;
  logic                      src_b_reg;
  logic                      accept;
  logic                      wb_hit_a;
  logic                      wb_hit_b;

  // Operand read: r0 is hard zero, a same-cycle writeback beats the file
  always_comb begin
    opnd_a = rf_rd_data_a;
    opnd_b = rf_rd_data_b;
    if (rs1 == '0)                       opnd_a = '0;
    else if (wb_en && (wb_addr == rs1))  opnd_a = wb_data;
    if (rs2 == '0)                       opnd_b = '0;
    else if (wb_en && (wb_addr == rs2))  opnd_b = wb_data;
  end

  // Opcode/function translation and legality check
  always_comb begin
    dec_legal    = 1'b1;
    dec_opcode   = OPC_TYPE_R;
    dec_function = '0;
    dec_b_reg    = 1'b0;
    dec_rd       = rd_i;
    dec_a        = opnd_a;
    dec_b        = imm_sext;
    case (op)
      6'h00: begin
        dec_b_reg = 1'b1;
        dec_rd    = rd_r;
        dec_b     = opnd_b;
        case (func)
          6'h20:   dec_function = OPCODE_WIDTH'(0);
          6'h22:   dec_function = OPCODE_WIDTH'(1);
          6'h24:   dec_function = OPCODE_WIDTH'(2);
          6'h25:   dec_function = OPCODE_WIDTH'(3);
          6'h0E:   dec_function = OPCODE_WIDTH'(4);
          6'h0F:   dec_function = OPCODE_WIDTH'(5);
          6'h28:   dec_function = OPCODE_WIDTH'(6);
          6'h2F:   dec_function = OPCODE_WIDTH'(7);
          default: dec_legal    = 1'b0;
        endcase
      end
      6'h08: dec_opcode = OPC_ADDI;
      6'h0A: dec_opcode = OPC_SUBI;
      6'h0C: begin
        dec_opcode = OPC_ANDI;
        dec_b      = imm_zext;
      end
      6'h0D: begin
        dec_opcode = OPC_ORI;
        dec_b      = imm_zext;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  assign instr_ready = !flush && (!alu_valid || alu_ready);
  assign accept      = instr_valid && instr_ready;
  assign wb_hit_a    = wb_en && (wb_addr != '0) && (wb_addr == src_a);
  assign wb_hit_b    = wb_en && (wb_addr != '0) && src_b_reg && (wb_addr == src_b);

  // Output pipeline register: load on accept, drop on retire/flush, forward while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_valid     <= 1'b0;
      illegal_instr <= 1'b0;
      alu_data_in_a <= '0;
      alu_data_in_b <= '0;
      alu_opcode    <= '0;
      alu_function  <= '0;
      alu_rd_en     <= 1'b0;
      alu_rd_addr   <= '0;
      src_a         <= '0;
      src_b         <= '0;
      src_b_reg     <= 1'b0;
    end else if (flush) begin
      alu_valid     <= 1'b0;
      illegal_instr <= 1'b0;
    end else if (accept) begin
      alu_valid     <= dec_legal;
      illegal_instr <= !dec_legal;
      if (dec_legal) begin
        alu_data_in_a <= dec_a;
        alu_data_in_b <= dec_b;
        alu_opcode    <= dec_opcode;
        alu_function  <= dec_function;
        alu_rd_en     <= (dec_rd != '0);
        alu_rd_addr   <= dec_rd;
        src_a         <= rs1;
        src_b         <= rs2;
        src_b_reg     <= dec_b_reg;
      end
    end else begin
      illegal_instr <= 1'b0;
      if (alu_valid && alu_ready) begin
        alu_valid <= 1'b0;
      end else if (alu_valid) begin
        if (wb_hit_a) alu_data_in_a <= wb_data;
        if (wb_hit_b) alu_data_in_b <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed scenarios with hand-derived constants plus
// randomized traffic checked against an instruction-level reference model.
`timescale 1ns/1ps
module tb_decode_issue;

  localparam int DW = 32;
  localparam int OW = 3;
  localparam int AW = 5;
  localparam int PW = 2*OW + 2*DW + 1 + AW;

  typedef struct packed {
    logic [2:0]  opc;
    logic [2:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd_en;
    logic [4:0]  rd;
  } pay_t;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst, flush, instr_valid, instr_ready;
  logic [31:0]   instr_data;
  logic [AW-1:0] rf_rd_addr_a, rf_rd_addr_b;
  logic [DW-1:0] rf_rd_data_a, rf_rd_data_b;
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          alu_valid, alu_ready;
  logic [DW-1:0] alu_data_in_a, alu_data_in_b;
  logic [OW-1:0] alu_opcode, alu_function;
  logic          alu_rd_en;
  logic [AW-1:0] alu_rd_addr;
  logic          illegal_instr;

  always #5 clk = ~clk;

  decode_issue #(.DATA_WIDTH(DW), .OPCODE_WIDTH(OW), .REG_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
    .rf_rd_data_a(rf_rd_data_a), .rf_rd_data_b(rf_rd_data_b),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_data_in_a(alu_data_in_a), .alu_data_in_b(alu_data_in_b),
    .alu_opcode(alu_opcode), .alu_function(alu_function),
    .alu_rd_en(alu_rd_en), .alu_rd_addr(alu_rd_addr),
    .illegal_instr(illegal_instr)
  );

  // Register file model answering the DUT's combinational reads
  logic [DW-1:0] regs [32];
  assign rf_rd_data_a = regs[rf_rd_addr_a];
  assign rf_rd_data_b = regs[rf_rd_addr_b];

  wire [PW-1:0] obs = {alu_opcode, alu_function, alu_data_in_a, alu_data_in_b, alu_rd_en, alu_rd_addr};

  // ---------------- scoreboard state ----------------
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [PW-1:0] exp_q[$];

  logic [5:0] r_funcs [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h0E, 6'h0F, 6'h28, 6'h2F};
  logic [5:0] i_ops   [4] = '{6'h08, 6'h0A, 6'h0C, 6'h0D};

  // ---------------- encoders / reference model ----------------
  function automatic logic [31:0] enc_r(input logic [4:0] s1, input logic [4:0] s2,
                                        input logic [4:0] d, input logic [5:0] f);
    return {6'h00, s1, s2, d, 5'd0, f};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] o, input logic [4:0] s1,
                                        input logic [4:0] d, input logic [15:0] imm);
    return {o, s1, d, imm};
  endfunction

  function automatic logic [31:0] reg_value(input logic [4:0] r, input logic we,
                                            input logic [4:0] wa, input logic [31:0] wd);
    if (r == 5'd0) return 32'd0;
    if (we && wa == r) return wd;
    return regs[r];
  endfunction

  // What the ALU should see for one instruction, from the ISA rules
  function automatic void ref_decode(input logic [31:0] ins, input logic we,
                                     input logic [4:0] wa, input logic [31:0] wd,
                                     output logic legal, output pay_t p,
                                     output logic [4:0] sa, output logic [4:0] sb,
                                     output logic breg);
    int   simm;
    int   fidx;
    legal = 1'b1;
    breg  = 1'b0;
    sa    = ins[25:21];
    sb    = ins[20:16];
    simm  = $signed(ins[15:0]);
    p.fn  = 3'd0;
    p.rd  = ins[20:16];
    p.a   = reg_value(ins[25:21], we, wa, wd);
    p.b   = 32'(simm);
    fidx  = -1;
    for (int i = 0; i < 8; i++) if (r_funcs[i] == ins[5:0]) fidx = i;
    case (ins[31:26])
      6'h00: begin
        p.opc = 3'd0;
        breg  = 1'b1;
        p.rd  = ins[15:11];
        p.b   = reg_value(ins[20:16], we, wa, wd);
        if (fidx < 0) legal = 1'b0;
        else p.fn = 3'(fidx);
      end
      6'h08: p.opc = 3'd1;
      6'h0A: p.opc = 3'd2;
      6'h0C: begin p.opc = 3'd3; p.b = {16'h0000, ins[15:0]}; end
      6'h0D: begin p.opc = 3'd4; p.b = {16'h0000, ins[15:0]}; end
      default: begin p.opc = 3'd0; legal = 1'b0; end
    endcase
    p.rd_en = (p.rd != 5'd0);
  endfunction

  function automatic logic [31:0] gen_instr(input bit allow_bad);
    int         k;
    logic [4:0] s1, s2, d;
    logic [5:0] o;
    k  = $urandom_range(0, allow_bad ? 13 : 11);
    s1 = 5'($urandom_range(0, 7));
    s2 = 5'($urandom_range(0, 7));
    d  = 5'($urandom_range(0, 7));
    if (k < 8)  return enc_r(s1, s2, d, r_funcs[k]);
    if (k < 12) return enc_i(i_ops[k-8], s1, d, 16'($urandom));
    if (k == 12) begin
      do o = 6'($urandom_range(1, 63));
      while (o == 6'h08 || o == 6'h0A || o == 6'h0C || o == 6'h0D);
      return {o, 26'($urandom)};
    end
    return enc_r(s1, s2, d, 6'h21);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    flush       = 1'b0;
    instr_valid = 1'b0;
    instr_data  = 32'd0;
    wb_en       = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
    alu_ready   = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    tick(); tick();
    n_checks++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", alu_valid); end
    n_checks++; if (illegal_instr !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", illegal_instr); end
    n_checks++; if (obs !== '0) begin n_fail++; $display("FAIL reset_payload: got %h want 0", obs); end
    rst = 1'b0;
    #1;
    n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
  endtask

  task automatic test_directed_ops();
    logic [31:0] ins [4];
    logic [PW-1:0] want [4];
    ins[0] = 32'h2023FFFF;                       // ADDI r3,r1,-1
    want[0] = {3'd1, 3'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 5'd3};
    ins[1] = enc_i(6'h0D, 5'd0, 5'd2, 16'h8000); // ORI r2,r0,0x8000
    want[1] = {3'd4, 3'd0, 32'd0, 32'h00008000, 1'b1, 5'd2};
    ins[2] = enc_r(5'd1, 5'd2, 5'd4, 6'h22);     // SUB r4,r1,r2 with wb r2=7
    want[2] = {3'd0, 3'd1, 32'd5, 32'd7, 1'b1, 5'd4};
    ins[3] = enc_i(6'h0C, 5'd1, 5'd0, 16'hF0F0); // ANDI r0,r1,0xF0F0
    want[3] = {3'd3, 3'd0, 32'd5, 32'h0000F0F0, 1'b0, 5'd0};
    regs[0] = 32'hDEADBEEF;
    regs[1] = 32'd5;
    regs[2] = 32'd9;
    for (int i = 0; i < 4; i++) begin
      instr_data  = ins[i];
      instr_valid = 1'b1;
      wb_en   = (i == 2);
      wb_addr = 5'd2;
      wb_data = 32'd7;
      #1;
      n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL op%0d_ready: got %b want 1", i, instr_ready); end
      n_checks++; if (rf_rd_addr_a !== ins[i][25:21]) begin n_fail++; $display("FAIL op%0d_rf_addr_a: got %0d want %0d", i, rf_rd_addr_a, ins[i][25:21]); end
      tick();
      instr_valid = 1'b0;
      wb_en = 1'b0;
      n_checks++; if (alu_valid !== 1'b1) begin n_fail++; $display("FAIL op%0d_valid: got %b want 1", i, alu_valid); end
      n_checks++; if (obs !== want[i]) begin n_fail++; $display("FAIL op%0d_payload: got %h want %h", i, obs, want[i]); end
      tick();
      n_checks++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL op%0d_retire: got %b want 0", i, alu_valid); end
    end
  endtask

  task automatic test_stall();
    logic [PW-1:0] want;
    regs[6] = 32'h11;
    regs[7] = 32'h22;
    want = {3'd0, 3'd0, 32'h11, 32'h22, 1'b1, 5'd5};
    alu_ready   = 1'b0;
    instr_data  = enc_r(5'd6, 5'd7, 5'd5, 6'h20);  // ADD r5,r6,r7
    instr_valid = 1'b1;
    tick();
    instr_data = enc_i(6'h0D, 5'd1, 5'd9, 16'h1234);  // offered but must wait
    for (int c = 0; c < 3; c++) begin
      wb_en   = (c == 1);
      wb_addr = 5'd7;
      wb_data = 32'h55;
      if (c == 2) want = {3'd0, 3'd0, 32'h11, 32'h55, 1'b1, 5'd5};
      #1;
      n_checks++; if (alu_valid !== 1'b1) begin n_fail++; $display("FAIL stall%0d_valid: got %b want 1", c, alu_valid); end
      n_checks++; if (obs !== want) begin n_fail++; $display("FAIL stall%0d_payload: got %h want %h", c, obs, want); end
      n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL stall%0d_ready: got %b want 0", c, instr_ready); end
      tick();
    end
    wb_en       = 1'b0;
    instr_valid = 1'b0;
    alu_ready   = 1'b1;
    tick();
    n_checks++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release: got %b want 0", alu_valid); end
  endtask

  task automatic test_illegal();
    logic [31:0] bad [2];
    bad[0] = 32'hFC000000;                      // op 6'h3F
    bad[1] = enc_r(5'd1, 5'd2, 5'd3, 6'h21);    // unknown function
    for (int i = 0; i < 2; i++) begin
      instr_data  = bad[i];
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      n_checks++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL ill%0d_valid: got %b want 0", i, alu_valid); end
      n_checks++; if (illegal_instr !== 1'b1) begin n_fail++; $display("FAIL ill%0d_pulse: got %b want 1", i, illegal_instr); end
      tick();
      n_checks++; if (illegal_instr !== 1'b0) begin n_fail++; $display("FAIL ill%0d_pulse_end: got %b want 0", i, illegal_instr); end
    end
  endtask

  task automatic test_back_to_back();
    logic       legal, breg;
    logic [4:0] sa, sb;
    pay_t       p;
    logic [PW-1:0] want;
    alu_ready = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      if (i > 0) begin
        want = exp_q.pop_front();
        n_checks++; if (alu_valid !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_valid: got %b want 1", i, alu_valid); end
        n_checks++; if (obs !== want) begin n_fail++; $display("FAIL b2b%0d_payload: got %h want %h", i, obs, want); end
      end
      if (i < 12) begin
        regs[$urandom_range(1, 7)] = $urandom;
        instr_data  = gen_instr(1'b0);
        instr_valid = 1'b1;
        wb_en   = 1'($urandom_range(0, 1));
        wb_addr = 5'($urandom_range(0, 7));
        wb_data = $urandom;
        #1;
        n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_ready: got %b want 1", i, instr_ready); end
        ref_decode(instr_data, wb_en, wb_addr, wb_data, legal, p, sa, sb, breg);
        exp_q.push_back(p);
      end else begin
        instr_valid = 1'b0;
        wb_en = 1'b0;
      end
      tick();
    end
    n_checks++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", alu_valid); end
  endtask

  task automatic test_flush();
    alu_ready   = 1'b0;
    instr_data  = enc_i(6'h08, 5'd1, 5'd4, 16'h0010);
    instr_valid = 1'b1;
    tick();
    n_checks++; if (alu_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre_valid: got %b want 1", alu_valid); end
    flush       = 1'b1;
    alu_ready   = 1'b1;
    instr_data  = 32'hFC000000;
    #1;
    n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", instr_ready); end
    tick();
    flush       = 1'b0;
    instr_valid = 1'b0;
    n_checks++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", alu_valid); end
    n_checks++; if (illegal_instr !== 1'b0) begin n_fail++; $display("FAIL flush_illegal: got %b want 0", illegal_instr); end
    tick();
    n_checks++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_accept: got %b want 0", alu_valid); end
  endtask

  task automatic test_rst_mid_stall();
    alu_ready   = 1'b0;
    instr_data  = enc_r(5'd6, 5'd7, 5'd8, 6'h24);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    n_checks++; if (alu_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got %b want 1", alu_valid); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b want 0", alu_valid); end
    n_checks++; if (obs !== '0) begin n_fail++; $display("FAIL rst_async_payload: got %h want 0", obs); end
    tick();
    rst = 1'b0;
    alu_ready = 1'b1;
    tick();
    n_checks++; if (alu_valid !== 1'b0) begin n_fail++; $display("FAIL rst_lost: got %b want 0", alu_valid); end
  endtask

  task automatic test_random();
    logic       m_valid, m_ill, m_breg, legal, breg, exp_ready;
    logic [4:0] m_sa, m_sb, sa, sb;
    pay_t       m_pay, p;
    m_valid = 1'b0; m_ill = 1'b0; m_breg = 1'b0; m_sa = '0; m_sb = '0; m_pay = '0;
    for (int c = 0; c < 400; c++) begin
      n_checks++; if (alu_valid !== m_valid) begin n_fail++; $display("FAIL rnd%0d_valid: got %b want %b", c, alu_valid, m_valid); end
      n_checks++; if (illegal_instr !== m_ill) begin n_fail++; $display("FAIL rnd%0d_illegal: got %b want %b", c, illegal_instr, m_ill); end
      if (m_valid) begin
        n_checks++; if (obs !== m_pay) begin n_fail++; $display("FAIL rnd%0d_payload: got %h want %h", c, obs, m_pay); end
      end
      regs[$urandom_range(1, 7)] = $urandom;
      flush       = ($urandom_range(0, 15) == 0);
      alu_ready   = ($urandom_range(0, 3) != 0);
      instr_valid = ($urandom_range(0, 3) != 0);
      instr_data  = gen_instr(1'b1);
      wb_en       = 1'($urandom_range(0, 1));
      wb_addr     = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      #1;
      exp_ready = !flush && (!m_valid || alu_ready);
      n_checks++; if (instr_ready !== exp_ready) begin n_fail++; $display("FAIL rnd%0d_ready: got %b want %b", c, instr_ready, exp_ready); end
      ref_decode(instr_data, wb_en, wb_addr, wb_data, legal, p, sa, sb, breg);
      if (flush) begin
        m_valid = 1'b0;
        m_ill   = 1'b0;
      end else if (instr_valid && exp_ready) begin
        m_valid = legal;
        m_ill   = !legal;
        if (legal) begin m_pay = p; m_sa = sa; m_sb = sb; m_breg = breg; end
      end else begin
        m_ill = 1'b0;
        if (m_valid && alu_ready) m_valid = 1'b0;
        else if (m_valid && wb_en && wb_addr != 5'd0) begin
          if (wb_addr == m_sa) m_pay.a = wb_data;
          if (m_breg && wb_addr == m_sb) m_pay.b = wb_data;
        end
      end
      tick();
    end
    drive_idle();
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'hDEADBEEF;
    test_reset();
    test_directed_ops();
    test_stall();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_rst_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
